// File: rtl/ins_cache_ml.sv
// ins_cache_ml: direct-mapped multi-line instruction cache between the fetch
// unit and the DDR burst interface. Hits return in one cycle; a miss refills
// the whole line with one DDR burst and then returns the requested word.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    invalidate every line
//   fetch_req, fetch_addr    fetch request (sampled while fetch_rdy=1)
//   fetch_rdy                cache idle, request can be accepted
//   instruction, ins_valid   returned word and its one-cycle valid pulse
//   addr_err                 request was beyond the program image
//   miss                     one-cycle pulse as a refill starts
//   load_times               completed refill counter (wraps)
//   ISA_read_req/addr, isa_read_len   DDR burst request, start byte address, length
//   rd_burst_data_valid, instruction_to_cache   incoming DDR beats
module ins_cache_ml #(
  parameter int unsigned ISA_WIDTH       = 30,
  parameter int unsigned ADDR_WIDTH_MEM  = 16,
  parameter int unsigned DDR_ADDR_WIDTH  = 28,
  parameter int unsigned LINE_DEPTH      = 16,
  parameter int unsigned NUM_LINES       = 4,
  parameter int unsigned TOTAL_ISA_DEPTH = 128,
  parameter int unsigned BYTES_PER_INS   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      fetch_req,
  input  logic [ADDR_WIDTH_MEM-1:0] fetch_addr,
  output logic                      fetch_rdy,
  output logic [ISA_WIDTH-1:0]      instruction,
  output logic                      ins_valid,
  output logic                      addr_err,
  output logic                      miss,
  output logic [9:0]                load_times,
  output logic                      ISA_read_req,
  output logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
  output logic [9:0]                isa_read_len,
  input  logic                      rd_burst_data_valid,
  input  logic [ISA_WIDTH-1:0]      instruction_to_cache
);

  localparam int unsigned OB    = $clog2(LINE_DEPTH);
  localparam int unsigned IB    = $clog2(NUM_LINES);
  localparam int unsigned IB_W  = (IB == 0) ? 1 : IB;
  localparam int unsigned TAG_W = ADDR_WIDTH_MEM - OB - IB;
  localparam int unsigned AW    = OB + IB;
  localparam int unsigned DEPTH = LINE_DEPTH * NUM_LINES;
  localparam int unsigned LEN_W = 10;

  typedef enum logic [1:0] {IDLE, RESP, REFILL, FILL_RESP} state_t;

  state_t                    state_q, state_d;
  logic [NUM_LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]          tag_mem [NUM_LINES];
  logic [ISA_WIDTH-1:0]      data_mem [DEPTH];
  logic [OB-1:0]             lat_off_q, lat_off_d;
  logic [OB-1:0]             cnt_q, cnt_d;
  logic [IB_W-1:0]           lat_idx_q, lat_idx_d;
  logic                      lat_err_q, lat_err_d;
  logic                      flushed_q, flushed_d;

  logic                      fetch_rdy_d, ins_valid_d, addr_err_d, miss_d, read_req_d;
  logic [ISA_WIDTH-1:0]      instruction_d;
  logic [LEN_W-1:0]          load_times_d, read_len_d;
  logic [DDR_ADDR_WIDTH-1:0] read_addr_d;

  // Request address decode
  logic [OB-1:0]             req_off;
  logic [IB_W-1:0]           req_idx;
  logic [TAG_W-1:0]          req_tag;
  logic [ADDR_WIDTH_MEM-1:0] line_base;
  logic [31:0]               remain, burst_len;
  logic                      out_of_range, hit, accept, beat, last_beat, tag_we;
  logic [AW-1:0]             rd_ptr, wr_ptr;

  assign req_off      = OB'(fetch_addr);
  assign req_idx      = (NUM_LINES == 1) ? '0 : IB_W'(fetch_addr >> OB);
  assign req_tag      = TAG_W'(fetch_addr >> (OB + IB));
  assign line_base    = fetch_addr & ~ADDR_WIDTH_MEM'(LINE_DEPTH - 1);
  assign out_of_range = 32'(fetch_addr) >= TOTAL_ISA_DEPTH;
  // The tail line of the program image may be shorter than a full line
  assign remain       = TOTAL_ISA_DEPTH - 32'(line_base);
  assign burst_len    = (remain < LINE_DEPTH) ? remain : LINE_DEPTH;
  // A flush in the lookup cycle makes the line look invalid
  assign hit          = valid_q[req_idx] && !flush && (tag_mem[req_idx] == req_tag);
  assign accept       = fetch_rdy && fetch_req && (state_q == IDLE);
  assign beat         = (state_q == REFILL) && rd_burst_data_valid;
  assign last_beat    = beat && (LEN_W'(cnt_q) == isa_read_len - LEN_W'(1));
  assign rd_ptr       = AW'({lat_idx_q, lat_off_q});
  assign wr_ptr       = AW'({lat_idx_q, cnt_q});

  // Next-state and registered-output values
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    cnt_d         = cnt_q;
    lat_off_d     = lat_off_q;
    lat_idx_d     = lat_idx_q;
    lat_err_d     = lat_err_q;
    flushed_d     = flushed_q;
    ins_valid_d   = 1'b0;
    addr_err_d    = 1'b0;
    miss_d        = 1'b0;
    instruction_d = '0;
    load_times_d  = load_times;
    read_addr_d   = ISA_read_addr;
    read_len_d    = isa_read_len;
    tag_we        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          lat_off_d = req_off;
          lat_idx_d = req_idx;
          lat_err_d = out_of_range;
          if (out_of_range || hit) begin
            state_d = RESP;
          end else begin
            state_d          = REFILL;
            miss_d           = 1'b1;
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b0;
            cnt_d            = '0;
            flushed_d        = 1'b0;
            read_addr_d      = DDR_ADDR_WIDTH'(line_base) * DDR_ADDR_WIDTH'(BYTES_PER_INS);
            read_len_d       = LEN_W'(burst_len);
          end
        end
      end
      RESP, FILL_RESP: begin
        state_d       = IDLE;
        ins_valid_d   = 1'b1;
        addr_err_d    = lat_err_q;
        instruction_d = lat_err_q ? '0 : data_mem[rd_ptr];
      end
      REFILL: begin
        if (beat) begin
          cnt_d = cnt_q + OB'(1);
          if (last_beat) begin
            state_d      = FILL_RESP;
            load_times_d = load_times + LEN_W'(1);
            // A flush seen at any point of the burst leaves the line invalid
            if (!flushed_q) valid_d[lat_idx_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides everything, including a line completing this edge
    if (flush) begin
      valid_d = '0;
      if (state_q == REFILL) flushed_d = 1'b1;
    end

    read_req_d  = (state_d == REFILL);
    fetch_rdy_d = (state_d == IDLE);
  end

  // State, control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      cnt_q         <= '0;
      lat_off_q     <= '0;
      lat_idx_q     <= '0;
      lat_err_q     <= 1'b0;
      flushed_q     <= 1'b0;
      fetch_rdy     <= 1'b0;
      instruction   <= '0;
      ins_valid     <= 1'b0;
      addr_err      <= 1'b0;
      miss          <= 1'b0;
      load_times    <= '0;
      ISA_read_req  <= 1'b0;
      ISA_read_addr <= '0;
      isa_read_len  <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      cnt_q         <= cnt_d;
      lat_off_q     <= lat_off_d;
      lat_idx_q     <= lat_idx_d;
      lat_err_q     <= lat_err_d;
      flushed_q     <= flushed_d;
      fetch_rdy     <= fetch_rdy_d;
      instruction   <= instruction_d;
      ins_valid     <= ins_valid_d;
      addr_err      <= addr_err_d;
      miss          <= miss_d;
      load_times    <= load_times_d;
      ISA_read_req  <= read_req_d;
      ISA_read_addr <= read_addr_d;
      isa_read_len  <= read_len_d;
    end
  end

  // Tag and data storage, not reset; beats are written even during a flush
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[req_idx] <= req_tag;
    if (beat)   data_mem[wr_ptr] <= instruction_to_cache;
  end

endmodule

// File: tb/tb_ins_cache_ml.sv
// Bench for ins_cache_ml: directed scenarios plus randomized fetches, checked
// cycle by cycle against a line-level model of the cache.
module tb_ins_cache_ml;

  localparam int TOTAL = 120;
  localparam int BIG   = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        fetch_rdy;
  logic [29:0] instruction;
  logic        ins_valid, addr_err, miss;
  logic [9:0]  load_times;
  logic        ISA_read_req;
  logic [27:0] ISA_read_addr;
  logic [9:0]  isa_read_len;
  logic        rd_burst_data_valid = 1'b0;
  logic [29:0] instruction_to_cache = '0;

  ins_cache_ml #(.TOTAL_ISA_DEPTH(TOTAL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_rdy(fetch_rdy), .instruction(instruction), .ins_valid(ins_valid),
    .addr_err(addr_err), .miss(miss), .load_times(load_times),
    .ISA_read_req(ISA_read_req), .ISA_read_addr(ISA_read_addr), .isa_read_len(isa_read_len),
    .rd_burst_data_valid(rd_burst_data_valid), .instruction_to_cache(instruction_to_cache)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  // Model: per-line valid/tag, expected response timing and DDR request window
  bit          mvalid [4];
  int          mtag [4];
  int          mload = 0;
  int          due_cyc = -1, miss_cyc = -1;
  int          busy_from = 0, busy_to = 0, rd_from = 0, rd_until = 0;
  int          exp_rd_addr = 0, exp_rd_len = 0;
  logic [29:0] exp_data = '0;
  bit          exp_err = 1'b0;
  bit          chk_en = 1'b0;

  // Observations used by the literal pins
  logic [29:0] last_instr = '0;
  bit          last_err = 1'b0;
  int          req_cycles = 0, miss_cnt = 0, seen_rd_addr = -1, seen_rd_len = -1;

  bit exp_v, exp_req, exp_rdy;

  function automatic logic [29:0] ddr_word(input int a);
    return 30'(32'h100 + a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
    mload = 0; due_cyc = -1; miss_cyc = -1;
    busy_from = 0; busy_to = 0; rd_from = 0; rd_until = 0;
  endtask

  // Compare process: every output every cycle while out of reset
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v   = (cyc == due_cyc);
      exp_req = (cyc >= rd_from) && (cyc < rd_until);
      exp_rdy = !((cyc >= busy_from) && (cyc < busy_to));
      chk("ins_valid", 64'(ins_valid), 64'(exp_v));
      if (exp_v) begin
        chk("instruction", 64'(instruction), 64'(exp_data));
        chk("addr_err", 64'(addr_err), 64'(exp_err));
      end
      if (ins_valid) begin
        last_instr = instruction;
        last_err   = addr_err;
      end
      chk("miss", 64'(miss), 64'(cyc == miss_cyc));
      if (miss) miss_cnt++;
      chk("ISA_read_req", 64'(ISA_read_req), 64'(exp_req));
      if (exp_req) begin
        chk("ISA_read_addr", 64'(ISA_read_addr), 64'(exp_rd_addr));
        chk("isa_read_len", 64'(isa_read_len), 64'(exp_rd_len));
      end
      if (ISA_read_req) begin
        req_cycles++;
        seen_rd_addr = int'(ISA_read_addr);
        seen_rd_len  = int'(isa_read_len);
      end
      chk("load_times", 64'(load_times), 64'(mload & 32'h3ff));
      chk("fetch_rdy", 64'(fetch_rdy), 64'(exp_rdy));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_fetch_rdy"}, 64'(fetch_rdy), 64'(0));
    chk({tag, "_ins_valid"}, 64'(ins_valid), 64'(0));
    chk({tag, "_instruction"}, 64'(instruction), 64'(0));
    chk({tag, "_addr_err"}, 64'(addr_err), 64'(0));
    chk({tag, "_miss"}, 64'(miss), 64'(0));
    chk({tag, "_load_times"}, 64'(load_times), 64'(0));
    chk({tag, "_ISA_read_req"}, 64'(ISA_read_req), 64'(0));
    chk({tag, "_ISA_read_addr"}, 64'(ISA_read_addr), 64'(0));
    chk({tag, "_isa_read_len"}, 64'(isa_read_len), 64'(0));
  endtask

  // mode: 0 plain, 1 flush with the request, 2 flush mid-burst,
  //       3 flush on the last beat, 4 reset mid-burst
  task automatic fetch(input logic [15:0] a, input int mode);
    int  off, idx, tag, base, len, n, gap;
    bit  oor, hit, flushed;
    for (int i = 0; i < 60 && !fetch_rdy; i++) @(negedge clk);
    if (!fetch_rdy) begin
      timeout_fail("fetch_rdy_wait");
      return;
    end
    fetch_req  = 1'b1;
    fetch_addr = a;
    flush      = (mode == 1);
    off  = int'(a) % 16;
    idx  = (int'(a) / 16) % 4;
    tag  = int'(a) / 64;
    base = int'(a) - off;
    oor  = int'(a) >= TOTAL;
    hit  = !oor && (mode != 1) && mvalid[idx] && (mtag[idx] == tag);
    if (mode == 1) for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
    @(posedge clk);
    #1;
    n          = cyc;
    fetch_req  = 1'b0;
    flush      = 1'b0;
    fetch_addr = 16'($urandom);
    busy_from  = n;
    if (oor || hit) begin
      exp_data = oor ? 30'd0 : ddr_word(int'(a));
      exp_err  = oor;
      due_cyc  = n + 1;
      busy_to  = n + 1;
    end else begin
      len         = (TOTAL - base < 16) ? TOTAL - base : 16;
      due_cyc     = BIG;
      busy_to     = BIG;
      miss_cyc    = n;
      rd_from     = n;
      rd_until    = BIG;
      exp_rd_addr = base * 8;
      exp_rd_len  = len;
      exp_data    = ddr_word(int'(a));
      exp_err     = 1'b0;
      mvalid[idx] = 1'b0;
      mtag[idx]   = tag;
      flushed     = 1'b0;
      @(negedge clk);
      for (int k = 0; k < len; k++) begin
        flush = 1'b0;
        gap   = int'($urandom_range(0, 2));
        repeat (gap) begin
          rd_burst_data_valid  = 1'b0;
          instruction_to_cache = 30'($urandom);
          @(negedge clk);
        end
        if (mode == 4 && k == 2) begin
          #2;
          rst = 1'b1;
          chk_en = 1'b0;
          rd_burst_data_valid = 1'b0;
          #1;
          check_all_zero("mid_reset");
          model_reset();
          repeat (2) @(negedge clk);
          rst = 1'b0;
          @(posedge clk);
          #1;
          chk_en = 1'b1;
          @(negedge clk);
          return;
        end
        rd_burst_data_valid  = 1'b1;
        instruction_to_cache = ddr_word(base + k);
        if ((mode == 2 && k == len / 2) || (mode == 3 && k == len - 1)) begin
          flush   = 1'b1;
          flushed = 1'b1;
          for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
        end
        if (k == len - 1) begin
          @(posedge clk);
          #1;
          rd_until = cyc;
          due_cyc  = cyc + 1;
          busy_to  = cyc + 1;
          mload++;
          if (!flushed) mvalid[idx] = 1'b1;
        end
        @(negedge clk);
      end
      rd_burst_data_valid = 1'b0;
      flush = 1'b0;
    end
    for (int i = 0; i < 200 && cyc < due_cyc; i++) @(negedge clk);
    if (cyc < due_cyc) timeout_fail("response_wait");
    #1;
  endtask

  // DDR beats while the cache is not refilling must be ignored
  task automatic idle_noise();
    repeat ($urandom_range(0, 3)) begin
      rd_burst_data_valid  = 1'($urandom);
      instruction_to_cache = 30'($urandom);
      @(negedge clk);
    end
    rd_burst_data_valid = 1'b0;
  endtask

  initial begin
    int r0, m0, r, a;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);

    fetch(16'h0005, 0);
    chk("pin_miss_data", 64'(last_instr), 64'(30'h105));
    chk("pin_miss_addr", 64'(seen_rd_addr), 64'(0));
    chk("pin_miss_len", 64'(seen_rd_len), 64'(16));
    chk("pin_load_1", 64'(load_times), 64'(1));

    r0 = req_cycles;
    fetch(16'h0007, 0);
    chk("pin_hit_data", 64'(last_instr), 64'(30'h107));
    chk("pin_hit_noreq", 64'(req_cycles), 64'(r0));

    fetch(16'h0045, 0);
    chk("pin_conflict_addr", 64'(seen_rd_addr), 64'(28'h200));
    fetch(16'h0005, 0);
    chk("pin_load_3", 64'(load_times), 64'(3));

    fetch(16'h0075, 0);
    chk("pin_tail_len", 64'(seen_rd_len), 64'(8));
    chk("pin_tail_addr", 64'(seen_rd_addr), 64'(28'h380));
    r0 = req_cycles;
    fetch(16'h0078, 0);
    chk("pin_oor_data", 64'(last_instr), 64'(0));
    chk("pin_oor_err", 64'(last_err), 64'(1));
    chk("pin_oor_noreq", 64'(req_cycles), 64'(r0));

    fetch(16'h0010, 2);
    chk("pin_flush_mid_data", 64'(last_instr), 64'(30'h110));
    m0 = miss_cnt;
    fetch(16'h0010, 0);
    chk("pin_flush_mid_remiss", 64'(miss_cnt), 64'(m0 + 1));

    fetch(16'h0020, 3);
    m0 = miss_cnt;
    fetch(16'h0020, 0);
    chk("pin_flush_last_remiss", 64'(miss_cnt), 64'(m0 + 1));
    m0 = miss_cnt;
    fetch(16'h0021, 0);
    chk("pin_hit_nomiss", 64'(miss_cnt), 64'(m0));
    fetch(16'h0022, 1);
    chk("pin_flush_idle_miss", 64'(miss_cnt), 64'(m0 + 1));

    fetch(16'h0015, 4);
    m0 = miss_cnt;
    fetch(16'h0005, 0);
    chk("pin_post_reset_miss", 64'(miss_cnt), 64'(m0 + 1));
    chk("pin_post_reset_load", 64'(load_times), 64'(1));

    for (int t = 0; t < 60; t++) begin
      a = int'($urandom_range(0, 127));
      r = int'($urandom_range(0, 9));
      idle_noise();
      fetch(16'(a), (r <= 6) ? 0 : r - 6);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
